// File: rtl/mvm_stream_param.sv
// Streaming signed matrix-vector multiplier y = A*x.
// Loads x then A row-major over one valid/ready stream, runs one MAC per cycle, and streams y out.
module mvm_stream_param #(
  parameter int M         = 3,
  parameter int N         = 3,
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2*WIDTH + $clog2(N) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WIDTH-1:0]     s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [ACC_WIDTH-1:0] m_data,
  output logic                 m_last,
  output logic                 done
);

  localparam int MN = M * N;
  localparam int XW = (N  > 1) ? $clog2(N)  : 1;
  localparam int AW = (MN > 1) ? $clog2(MN) : 1;
  localparam int YW = (M  > 1) ? $clog2(M)  : 1;

  typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_A, MAC, OUT} state_t;
  state_t state;

  logic signed [WIDTH-1:0]     x_mem [N];
  logic signed [WIDTH-1:0]     a_mem [MN];
  logic signed [ACC_WIDTH-1:0] y_mem [M];

  logic [XW-1:0] x_cnt, i_col;
  logic [AW-1:0] a_cnt, i_idx;
  logic [YW-1:0] i_row, r1, r2, out_idx;
  logic          issue_on;

  // Three-stage MAC pipeline: memory read, multiply, accumulate.
  logic                        v1, v2, first1, first2, lastc1, lastc2, lastall1, lastall2;
  logic signed [WIDTH-1:0]     rd_a, rd_x;
  logic signed [2*WIDTH-1:0]   prod;
  logic signed [ACC_WIDTH-1:0] acc, p_ext, acc_sum;

  logic accept;

  assign s_ready = !reset && (state == IDLE || state == LOAD_X || state == LOAD_A);
  assign accept  = s_valid && s_ready;
  assign p_ext   = {{(ACC_WIDTH-2*WIDTH){prod[2*WIDTH-1]}}, prod};
  assign acc_sum = (first2 ? '0 : acc) + p_ext;

  // NOTE: memories and pure datapath registers carry no reset; every value is written before it is used.
  always_ff @(posedge clk) begin
    if (accept && (state == IDLE || state == LOAD_X)) x_mem[x_cnt] <= s_data;
    if (accept && state == LOAD_A) a_mem[a_cnt] <= s_data;
    if (issue_on) begin
      rd_a   <= a_mem[i_idx];
      rd_x   <= x_mem[i_col];
      r1     <= i_row;
      first1 <= (i_col == '0);
      lastc1 <= (i_col == XW'(N-1));
    end
    prod   <= (2*WIDTH)'(rd_a) * (2*WIDTH)'(rd_x);
    r2     <= r1;
    first2 <= first1;
    lastc2 <= lastc1;
    if (v2) begin
      acc <= acc_sum;
      if (lastc2) y_mem[r2] <= acc_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      x_cnt    <= '0;
      a_cnt    <= '0;
      i_idx    <= '0;
      i_col    <= '0;
      i_row    <= '0;
      issue_on <= 1'b0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      lastall1 <= 1'b0;
      lastall2 <= 1'b0;
      out_idx  <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_last   <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      v1       <= issue_on;
      lastall1 <= issue_on && (i_idx == AW'(MN-1));
      v2       <= v1;
      lastall2 <= v1 && lastall1;
      case (state)
        IDLE, LOAD_X: begin
          if (accept) begin
            if (x_cnt == XW'(N-1)) begin
              x_cnt <= '0;
              state <= LOAD_A;
            end else begin
              x_cnt <= x_cnt + XW'(1);
              state <= LOAD_X;
            end
          end
        end
        LOAD_A: begin
          if (accept) begin
            if (a_cnt == AW'(MN-1)) begin
              a_cnt    <= '0;
              issue_on <= 1'b1;
              state    <= MAC;
            end else begin
              a_cnt <= a_cnt + AW'(1);
            end
          end
        end
        MAC: begin
          if (issue_on) begin
            if (i_idx == AW'(MN-1)) begin
              issue_on <= 1'b0;
              i_idx    <= '0;
              i_col    <= '0;
              i_row    <= '0;
            end else begin
              i_idx <= i_idx + AW'(1);
              if (i_col == XW'(N-1)) begin
                i_col <= '0;
                i_row <= i_row + YW'(1);
              end else begin
                i_col <= i_col + XW'(1);
              end
            end
          end
          if (v2 && lastall2) begin
            out_idx <= '0;
            state   <= OUT;
          end
        end
        OUT: begin
          if (!m_valid || m_ready) begin
            if (m_valid && m_last) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              done    <= 1'b1;
              state   <= IDLE;
            end else begin
              m_valid <= 1'b1;
              m_data  <= y_mem[out_idx];
              m_last  <= (out_idx == YW'(M-1));
              out_idx <= (out_idx == YW'(M-1)) ? '0 : out_idx + YW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_stream_param.sv
// Bench for mvm_stream_param: a 3x3 and a 2x4 instance driven by directed and random vectors,
// with results compared against a dot-product model.
module tb_mvm_stream_param;

  localparam int W    = 8;
  localparam int ACC0 = 2*W + $clog2(3) + 1;
  localparam int ACC1 = 2*W + $clog2(4) + 1;

  logic            clk;
  logic            reset;
  logic            s_valid [2];
  logic            s_ready [2];
  logic [W-1:0]    s_data  [2];
  logic            m_valid [2];
  logic            m_ready [2];
  logic            m_last  [2];
  logic            done    [2];
  logic [ACC0-1:0] m_data0;
  logic [ACC1-1:0] m_data1;

  mvm_stream_param #(.M(3), .N(3), .WIDTH(W)) dut0 (
    .clk(clk), .reset(reset),
    .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]),
    .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data0),
    .m_last(m_last[0]), .done(done[0])
  );

  mvm_stream_param #(.M(2), .N(4), .WIDTH(W)) dut1 (
    .clk(clk), .reset(reset),
    .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]),
    .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data1),
    .m_last(m_last[1]), .done(done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int     checks = 0;
  int     errors = 0;
  int     t_last = 0;
  int     vx[$];
  int     va[$];
  longint exp_q[$];

  task automatic check(string tag, longint obs, longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint md(int u);
    return (u == 1) ? longint'($signed(m_data1)) : longint'($signed(m_data0));
  endfunction

  // y[i] = sum over j of A[i][j]*x[j], with A taken row-major from va.
  function automatic void compute(int m, int n);
    exp_q.delete();
    for (int i = 0; i < m; i++) begin
      longint s = 0;
      for (int j = 0; j < n; j++) s += longint'(va[i*n+j]) * longint'(vx[j]);
      exp_q.push_back(s);
    end
  endfunction

  function automatic void rand_vec(int m, int n);
    vx.delete();
    va.delete();
    for (int j = 0; j < n; j++)   vx.push_back(int'($urandom_range(0, 255)) - 128);
    for (int k = 0; k < m*n; k++) va.push_back(int'($urandom_range(0, 255)) - 128);
  endfunction

  task automatic send_beat(int u, int val, int gap);
    int b = 0;
    repeat (gap) begin
      s_valid[u] = 1'b0;
      @(posedge clk); #1;
    end
    s_valid[u] = 1'b1;
    s_data[u]  = W'(val);
    while (!s_ready[u] && b < 100) begin
      @(posedge clk); #1;
      b++;
    end
    if (b >= 100) check("s_ready_timeout", 0, 1);
    @(posedge clk); #1;
    s_valid[u] = 1'b0;
  endtask

  // gmode: 0 no gaps, 1 one idle cycle before every beat, 2 random gaps
  task automatic send_vec(int u, int gmode);
    int g;
    foreach (vx[j]) begin
      g = (gmode == 2) ? int'($urandom_range(0, 2)) : gmode;
      send_beat(u, vx[j], g);
    end
    foreach (va[k]) begin
      g = (gmode == 2) ? int'($urandom_range(0, 2)) : gmode;
      send_beat(u, va[k], g);
    end
    t_last = cyc;
  endtask

  // rmode: 0 always ready, 1 pattern 1,0,0,1,0,1 from first m_valid, 2 random
  task automatic recv(int u, int m, int n, int rmode);
    int     h = 0, k = 0, lat = -1, dones = 0, pc = 0;
    logic   mv, ml, mr, pstall = 1'b0, heldl = 1'b0;
    longint d, held = 0;
    bit     hold_ok = 1'b1;
    bit     pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    while (h < m && k < 400) begin
      mv = m_valid[u];
      ml = m_last[u];
      d  = md(u);
      if (done[u]) dones++;
      if (mv && lat < 0) lat = cyc - t_last;
      if (pstall && (!mv || d != held || ml != heldl)) hold_ok = 1'b0;
      case (rmode)
        1:       mr = (lat < 0) ? 1'b1 : pat[pc % 6];
        2:       mr = 1'($urandom_range(0, 1));
        default: mr = 1'b1;
      endcase
      if (lat >= 0) pc++;
      m_ready[u] = mr;
      pstall = mv && !mr;
      held   = d;
      heldl  = ml;
      @(posedge clk); #1;
      k++;
      if (mv && mr) begin
        check($sformatf("y%0d_u%0d", h, u), d, exp_q[h]);
        check($sformatf("last%0d_u%0d", h, u), longint'(ml), longint'(h == m-1));
        h++;
      end
    end
    m_ready[u] = 1'b1;
    check("handshakes", h, m);
    check("latency", lat, m*n + 3);
    check("hold_stable", longint'(hold_ok), 1);
    check("no_early_done", dones, 0);
    check("done_pulse", longint'(done[u]), 1);
    check("m_valid_after", longint'(m_valid[u]), 0);
    check("s_ready_b2b", longint'(s_ready[u]), 1);
  endtask

  initial begin
    int bad;
    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin
      s_valid[u] = 1'b0;
      s_data[u]  = '0;
      m_ready[u] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", longint'(s_ready[0]), 0);
    check("rst_m_valid", longint'(m_valid[0]), 0);
    check("rst_m_data", md(0), 0);
    check("rst_m_last", longint'(m_last[0]), 0);
    check("rst_done", longint'(done[0]), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("s_ready_after_rst", longint'(s_ready[0]), 1);
    check("s_ready_after_rst_u1", longint'(s_ready[1]), 1);

    // Defaults
    vx = '{1, 2, 3};
    va = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    compute(3, 3);
    send_vec(0, 0);
    recv(0, 3, 3, 0);

    // Extremes
    vx = '{-128, -128, -128};
    va = '{-128, -128, -128, -128, -128, -128, -128, -128, -128};
    compute(3, 3);
    send_vec(0, 0);
    recv(0, 3, 3, 0);
    vx = '{127, 127, 127};
    compute(3, 3);
    send_vec(0, 0);
    recv(0, 3, 3, 0);

    // Backpressure
    vx = '{1, 2, 3};
    va = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    compute(3, 3);
    send_vec(0, 0);
    recv(0, 3, 3, 1);

    // Input gaps every other cycle
    send_vec(0, 1);
    recv(0, 3, 3, 0);

    // Reset on the 5th A beat
    foreach (vx[j]) send_beat(0, vx[j], 0);
    for (int k = 0; k < 4; k++) send_beat(0, va[k], 0);
    s_valid[0] = 1'b1;
    s_data[0]  = W'(va[4]);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_s_ready", longint'(s_ready[0]), 0);
    check("midrst_m_valid", longint'(m_valid[0]), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    s_valid[0] = 1'b0;
    bad = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (m_valid[0] || done[0]) bad++;
    end
    check("midrst_quiet", bad, 0);
    check("midrst_idle_ready", longint'(s_ready[0]), 1);
    send_vec(0, 0);
    recv(0, 3, 3, 0);

    // M=2, N=4 directed, then a back-to-back random vector
    vx = '{1, -1, 2, -2};
    va = '{1, 2, 3, 4, -5, 6, -7, 8};
    compute(2, 4);
    send_vec(1, 0);
    recv(1, 2, 4, 0);
    rand_vec(2, 4);
    compute(2, 4);
    send_vec(1, 0);
    recv(1, 2, 4, 2);

    // Random vectors with random gaps and backpressure
    for (int r = 0; r < 4; r++) begin
      rand_vec(3, 3);
      compute(3, 3);
      send_vec(0, 2);
      recv(0, 3, 3, 2);
      rand_vec(2, 4);
      compute(2, 4);
      send_vec(1, 2);
      recv(1, 2, 4, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
